// File: rtl/data_randomizer_if.sv
// -----------------------------------------------------------------------------
// data_randomizer_if
//  Wishbone-style single-beat write bus used on both sides of the 802.22 bit
//  randomizer.
//  Signals (names as seen by the randomizer):
//    dat  DATA_W  payload beat (DAT_I / DAT_O)
//    cyc  1       burst/frame active (CYC_I / CYC_O)
//    stb  1       beat valid (STB_I / STB_O)
//    we   1       write qualifier (WE_I / WE_O)
//    ack  1       beat accepted (ACK_O upstream / ACK_I downstream)
//  Modports:
//    master  drives dat/cyc/stb/we and receives ack
//    slave   receives dat/cyc/stb/we and drives ack
// -----------------------------------------------------------------------------
interface data_randomizer_if #(
  parameter int DATA_W = 6
) ();
  logic [DATA_W-1:0] dat;
  logic              cyc;
  logic              stb;
  logic              we;
  logic              ack;

  modport master (output dat, output cyc, output stb, output we, input ack);
  modport slave  (input dat, input cyc, input stb, input we, output ack);
endinterface

// File: rtl/data_randomizer.sv
// -----------------------------------------------------------------------------
// data_randomizer
//  Bit randomizer at the head of the 802.22 TX chain. Each accepted 6-bit beat
//  is XORed with six steps of the PRBS x^15+x^14+1 (MSB first in time) and
//  queued in a 2-entry buffer that feeds the QPSK modulator. The LFSR reloads
//  SEED at every frame boundary (CYC_I low) and, when FRAME_BEATS != 0, after
//  every FRAME_BEATS accepted beats.
//
//  Parameters:
//    SEED         LFSR value loaded at reset and at each frame start
//    FRAME_BEATS  beats per frame before a forced reseed (0 = CYC_I drop only)
//
//  Ports:
//    CLK_I        clock, rising edge
//    RST_I        synchronous active-high reset
//    up (slave)   upstream bus: dat=DAT_I, cyc=CYC_I, stb=STB_I, we=WE_I,
//                 ack=ACK_O (combinational)
//    dn (master)  downstream bus: dat=DAT_O, cyc=CYC_O, stb=STB_O, we=WE_O,
//                 ack=ACK_I
//    BYP_I        randomizer bypass, only with RANDOMIZER_BYPASS_EN
//
//  Build option:
//    RANDOMIZER_BYPASS_EN  adds BYP_I; sampled on the first accepted beat of a
//                          frame and held for that frame. When set, beats pass
//                          through unchanged and the LFSR is frozen.
// -----------------------------------------------------------------------------
module data_randomizer #(
  parameter logic [14:0] SEED        = 15'h7FFF,
  parameter int          FRAME_BEATS = 0
) (
  input  logic                CLK_I,
  input  logic                RST_I,
`ifdef RANDOMIZER_BYPASS_EN
  input  logic                BYP_I,
`endif
  data_randomizer_if.slave    up,
  data_randomizer_if.master   dn
);

  localparam int DATA_W = 6;
  localparam int CNT_W  = (FRAME_BEATS == 0) ? 1 : $clog2(FRAME_BEATS + 1);
  localparam logic [CNT_W-1:0] FB_LAST = CNT_W'(FRAME_BEATS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [14:0]       lfsr_q, lfsr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        fill_q, fill_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];

  logic              accept;
  logic              pop;
  logic [20:0]       scr;
  logic [DATA_W-1:0] beat_out;
  logic [14:0]       lfsr_adv;
  logic              byp_now;

  // Six serial LFSR steps folded into one cycle; returns {next_lfsr, data}.
  function automatic logic [20:0] scramble(input logic [14:0]       lfsr_in,
                                           input logic [DATA_W-1:0] din);
    logic [14:0]       l;
    logic [DATA_W-1:0] o;
    logic              fb;
    l = lfsr_in;
    o = din;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb   = l[14] ^ l[13];
      o[i] = din[i] ^ fb;
      l    = {l[13:0], fb};
    end
    return {l, o};
  endfunction

  // No accepts while draining the previous frame; the next frame waits for IDLE.
  assign accept = !RST_I && up.cyc && up.stb && up.we &&
                  (fill_q != 2'd2) && (state_q != DRAIN);
  assign pop    = (fill_q != 2'd0) && dn.ack;

`ifdef RANDOMIZER_BYPASS_EN
  logic byp_q, byp_d;

  // First beat of a frame sees BYP_I directly; later beats use the held value.
  assign byp_now = (state_q == IDLE) ? BYP_I : byp_q;

  always_comb begin
    byp_d = byp_q;
    if (accept && (state_q == IDLE)) begin
      byp_d = BYP_I;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      byp_q <= 1'b0;
    end else begin
      byp_q <= byp_d;
    end
  end
`else
  assign byp_now = 1'b0;
`endif

  assign scr      = scramble(lfsr_q, up.dat);
  assign beat_out = byp_now ? up.dat : scr[DATA_W-1:0];
  assign lfsr_adv = byp_now ? lfsr_q : scr[20:DATA_W];

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    fill_d   = fill_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    mem_d    = mem_q;

    if (accept) begin
      mem_d[wr_ptr_q] = beat_out;
      wr_ptr_d        = ~wr_ptr_q;
      lfsr_d          = lfsr_adv;
      cnt_d           = cnt_q + CNT_W'(1);
      // The beat that completes a frame used the old LFSR; the next gets SEED.
      if ((FRAME_BEATS != 0) && ((cnt_q + CNT_W'(1)) == FB_LAST)) begin
        lfsr_d = SEED;
        cnt_d  = '0;
      end
    end

    // Frame boundary: CYC_I low reloads the sequence.
    if (!up.cyc) begin
      lfsr_d = SEED;
      cnt_d  = '0;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({accept, pop})
      2'b10:   fill_d = fill_q + 2'd1;
      2'b01:   fill_d = fill_q - 2'd1;
      default: fill_d = fill_q;
    endcase

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!up.cyc) begin
          state_d = (fill_d != 2'd0) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (fill_d == 2'd0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      cnt_q    <= '0;
      fill_q   <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      fill_q   <= fill_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Buffer storage carries no reset; fill_q alone decides what is valid.
  always_ff @(posedge CLK_I) begin
    mem_q <= mem_d;
  end

  assign up.ack = accept;
  assign dn.dat = (fill_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
  assign dn.stb = (fill_q != 2'd0);
  assign dn.we  = (fill_q != 2'd0);
  assign dn.cyc = (state_q != IDLE);

endmodule
